writeback_arb: RTL

WRITEBACK_ARB -- requirements
Module: writeback_arb

---
 rtl/writeback_arb_if.sv | 31 +++
 rtl/writeback_arb.sv | 96 +++++++++
 2 files changed

// File: rtl/writeback_arb_if.sv
// Writeback arbiter bus: ALU and load result handshakes plus register-file write outputs.
// Latency: none (wires only).
// Backpressure: alu_ready / ld_ready are driven by the arbiter back toward the producers.
interface writeback_arb_if #(
  parameter int FIFO_DEPTH = 4
);
  logic                        alu_valid;
  logic                        alu_ready;
  logic [9:0]                  alu_addr;
  logic [31:0]                 alu_data;
  logic                        ld_valid;
  logic                        ld_ready;
  logic [9:0]                  ld_addr;
  logic [31:0]                 ld_data;
  logic [9:0]                  tick_waddr;
  logic [31:0]                 tick_wdata;
  logic                        tick_wren;
  logic [$clog2(FIFO_DEPTH):0] ld_count;

  // producer / checker side
  modport master (
    output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
    input  alu_ready, ld_ready, tick_waddr, tick_wdata, tick_wren, ld_count
  );

  // arbiter side
  modport slave (
    input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
    output alu_ready, ld_ready, tick_waddr, tick_wdata, tick_wren, ld_count
  );
endinterface

// File: rtl/writeback_arb.sv
// Register-file writeback arbiter: ALU results win, loads wait in an in-order buffer.
// Latency: ALU result 1 cycle; buffered load at least 2 cycles (no bypass).
// Backpressure: ld_ready drops when the buffer is full; alu_ready drops for one cycle when the load head has starved.
module writeback_arb #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 7
) (
  input  logic           clock,
  input  logic           reset_n,
  writeback_arb_if.slave wb
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [3:0]    LIMIT_C = 4'(STARVE_LIMIT);

  logic [41:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [3:0]    starve_cnt;
  logic [41:0]   head;
  logic          empty;
  logic          force_ld;
  logic          alu_eff;
  logic          push;
  logic          pop;

  assign empty        = (cnt == '0);
  assign head         = mem[rd_ptr];
  // once the head has waited STARVE_LIMIT cycles, steal exactly one ALU slot
  assign force_ld     = (starve_cnt == LIMIT_C) && !empty;
  assign wb.alu_ready = reset_n && !force_ld;
  // a full buffer never accepts, even if it drains this cycle
  assign wb.ld_ready  = reset_n && (cnt < DEPTH_C);
  // ALU writes to x0 take the slot away from nobody: the buffer drains instead
  assign alu_eff      = wb.alu_valid && wb.alu_ready && (wb.alu_addr[4:0] != 5'd0);
  assign push         = wb.ld_valid && wb.ld_ready;
  assign pop          = reset_n && !empty && !alu_eff;
  assign wb.ld_count  = cnt;

  // load buffer storage, deliberately not reset
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {wb.ld_addr, wb.ld_data};
    end
  end

  // pointers and occupancy; pointers wrap naturally since depth is a power of two
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // count cycles the head has been waiting behind ALU traffic
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (empty || pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT_C) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // registered register-file write port; address/data hold when idle
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wb.tick_wren  <= 1'b0;
      wb.tick_waddr <= '0;
      wb.tick_wdata <= '0;
    end else if (alu_eff) begin
      wb.tick_wren  <= 1'b1;
      wb.tick_waddr <= wb.alu_addr;
      wb.tick_wdata <= wb.alu_data;
    end else if (pop) begin
      // a load targeting x0 is drained but never written
      wb.tick_wren  <= (head[36:32] != 5'd0);
      wb.tick_waddr <= head[41:32];
      wb.tick_wdata <= head[31:0];
    end else begin
      wb.tick_wren  <= 1'b0;
    end
  end
endmodule
